// File: rtl/id_ex_pkg.sv
// Package id_ex_pkg
// Shared definitions for the ID/EX pipeline stage. It holds the width and
// bit positions of the 8-bit control bundle, the ALUOp encodings and a
// packed struct view of that bundle.
// Bundle packing, MSB first:
//   {Branch, MemRead, MemToReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
package id_ex_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_BRANCH   = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUOP_HI = 4;
  localparam int CTRL_ALUOP_LO = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGWRITE = 0;

  // ALUOp encodings: add for address generation (ld/sd), subtract-compare
  // for branches, and "decode funct" for R-type/I-type arithmetic.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Field order matches the bit-index constants above, so a cast between
  // ctrl_t and logic [CTRL_W-1:0] keeps every bit in place.
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Module hazard_detect_unit
// Combinational load-use hazard detection. A hazard exists when the
// instruction in EX is a real load writing a non-zero register that the
// instruction in ID reads.
// Ports:
//   ex_valid, ex_mem_read, ex_rd : state of the instruction currently in EX
//   id_valid, id_rs1, id_rs2     : the instruction waiting in ID
//   hazard                       : 1 = ID must wait one cycle for the load data
module hazard_detect_unit
  import id_ex_pkg::*;
#(
  parameter int RADDR_W = 5
) (
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  output logic               hazard
);

  logic rd_nonzero;
  logic src_match;

  // Both sources are always compared, even for formats without rs2. A false
  // match only costs a bubble, which is cheaper than decoding the format here.
  // x0 is never a real destination, so a load into x0 cannot create a hazard.
  always_comb begin
    rd_nonzero = (ex_rd != '0);
    src_match  = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    hazard     = ex_valid && ex_mem_read && rd_nonzero && src_match && id_valid;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Module id_ex_stage
// ID/EX pipeline register. It captures the decoded control bundle, the
// operands, the immediate and the register indices of the ID instruction.
// It inserts a bubble on a load-use hazard or a flush, and it freezes on hold.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   id_*                   : ID-stage instruction fields (valid, pc, data, imm,
//                            indices, funct, control bundle)
//   flush_i                : kill the ID->EX transfer (taken branch)
//   hold_i                 : freeze the whole stage (downstream busy)
//   stall_o                : freeze PC / IF-ID (hazard or hold)
//   ex_*                   : registered copies presented to EX
//   bubble_cnt, flush_cnt  : saturating event counters
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [3:0]         id_funct,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [3:0]         ex_funct,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               valid_q,     valid_d;
  logic [XLEN-1:0]    pc_q,        pc_d;
  logic [XLEN-1:0]    rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]    rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]    imm_q,       imm_d;
  logic [RADDR_W-1:0] rs1_q,       rs1_d;
  logic [RADDR_W-1:0] rs2_q,       rs2_d;
  logic [RADDR_W-1:0] rd_q,        rd_d;
  logic [3:0]         funct_q,     funct_d;
  logic [CTRL_W-1:0]  ctrl_q,      ctrl_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q,  flush_cnt_d;

  logic  hazard;
  ctrl_t ex_ctrl_s;

  assign ex_ctrl_s = ctrl_t'(ctrl_q);

  hazard_detect_unit #(
    .RADDR_W (RADDR_W)
  ) u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ex_ctrl_s.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // The hazard term is masked during reset: the EX contents are about to be
  // cleared, so only an external hold may freeze the front end in that cycle.
  assign stall_o = (hazard && !reset) || hold_i;

  // Next-state selection. Hold freezes everything. A flush beats a hazard:
  // the ID instruction is dead anyway, so it counts only as a flush bubble.
  // Bubbles carry an all-zero control bundle and never write state.
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct_d      = funct_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (hold_i) begin
      valid_d = valid_q;
    end else if (flush_i || hazard) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct_d    = '0;
      ctrl_d     = '0;
      if (flush_i) begin
        if (id_valid && (flush_cnt_q != '1)) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end else if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      funct_d    = id_funct;
      ctrl_d     = id_valid ? id_ctrl : '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct_q      <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct_q      <= funct_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct    = funct_q;
  assign ex_ctrl     = ctrl_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. The DUT counters are narrowed to 4 bits so
// that saturation can be reached in a short run. The expected EX register
// contents and the expected counter values come from a behavioural model.
module tb_id_ex_stage;

  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] CTRL_ADD = 8'b0001_0001;
  localparam logic [7:0] CTRL_LD  = 8'b0110_0011;

  logic               clk;
  logic               reset;
  logic               id_valid;
  logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]         id_funct;
  logic [7:0]         id_ctrl;
  logic               flush_i, hold_i;
  logic               stall_o;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]         ex_funct;
  logic [7:0]         ex_ctrl;
  logic [CNT_W-1:0]   bubble_cnt, flush_cnt;

  id_ex_stage #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_funct    (id_funct),
    .id_ctrl     (id_ctrl),
    .flush_i     (flush_i),
    .hold_i      (hold_i),
    .stall_o     (stall_o),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_funct    (ex_funct),
    .ex_ctrl     (ex_ctrl),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: what EX should hold, and the event counts.
  logic               mValid;
  logic [XLEN-1:0]    mPc, mRs1Data, mRs2Data, mImm;
  logic [RADDR_W-1:0] mRs1, mRs2, mRd;
  logic [3:0]         mFunct;
  logic [7:0]         mCtrl;
  int                 mBubbles, mFlushes;
  logic               lastStall;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clearModel();
    mValid = 1'b0; mPc = '0; mRs1Data = '0; mRs2Data = '0; mImm = '0;
    mRs1 = '0; mRs2 = '0; mRd = '0; mFunct = '0; mCtrl = '0;
  endtask

  // One clock cycle with the inputs as currently driven. The combinational
  // stall is checked first, then the model advances and the registered
  // outputs are compared just after the edge.
  task automatic applyStimulus();
    logic hz, expStall;
    #2;
    hz = mValid && mCtrl[6] && (mRd != 0) && ((mRd == id_rs1) || (mRd == id_rs2)) && id_valid;
    expStall = reset ? hold_i : (hz || hold_i);
    checkOutput("stall_o", {63'd0, stall_o}, {63'd0, expStall});
    lastStall = expStall;
    if (reset) begin
      clearModel();
      mBubbles = 0; mFlushes = 0;
    end else if (hold_i) begin
      mValid = mValid;
    end else if (flush_i) begin
      clearModel();
      if (id_valid && mFlushes < CNT_MAX) mFlushes++;
    end else if (hz) begin
      clearModel();
      if (mBubbles < CNT_MAX) mBubbles++;
    end else begin
      mValid = id_valid; mPc = id_pc; mRs1Data = id_rs1_data; mRs2Data = id_rs2_data;
      mImm = id_imm; mRs1 = id_rs1; mRs2 = id_rs2; mRd = id_rd; mFunct = id_funct;
      mCtrl = id_valid ? id_ctrl : 8'h00;
    end
    @(posedge clk);
    #1;
    checkOutput("ex_valid",    {63'd0, ex_valid}, {63'd0, mValid});
    checkOutput("ex_pc",       ex_pc, mPc);
    checkOutput("ex_rs1_data", ex_rs1_data, mRs1Data);
    checkOutput("ex_rs2_data", ex_rs2_data, mRs2Data);
    checkOutput("ex_imm",      ex_imm, mImm);
    checkOutput("ex_rs1",      64'(ex_rs1), 64'(mRs1));
    checkOutput("ex_rs2",      64'(ex_rs2), 64'(mRs2));
    checkOutput("ex_rd",       64'(ex_rd), 64'(mRd));
    checkOutput("ex_funct",    64'(ex_funct), 64'(mFunct));
    checkOutput("ex_ctrl",     64'(ex_ctrl), 64'(mCtrl));
    checkOutput("bubble_cnt",  64'(bubble_cnt), 64'(mBubbles));
    checkOutput("flush_cnt",   64'(flush_cnt), 64'(mFlushes));
  endtask

  task automatic setInstr(input logic v, input int rs1, input int rs2, input int rd,
                          input logic [7:0] ctrl);
    id_valid    = v;
    id_pc       = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm      = {$urandom, $urandom};
    id_rs1      = RADDR_W'(rs1);
    id_rs2      = RADDR_W'(rs2);
    id_rd       = RADDR_W'(rd);
    id_funct    = 4'($urandom);
    id_ctrl     = ctrl;
  endtask

  // Present one instruction and keep it in ID while the stage stalls,
  // as a frozen IF/ID would. Returns the number of stall cycles seen.
  task automatic sendInstr(input int rs1, input int rs2, input int rd,
                           input logic [7:0] ctrl, output int stalls);
    setInstr(1'b1, rs1, rs2, rd, ctrl);
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      if (!lastStall) break;
      stalls++;
    end
    if (stalls >= 4) checkOutput("stall_bound", 64'(stalls), 64'd0);
  endtask

  initial begin
    int st;
    int bBefore;
    reset = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    lastStall = 1'b0; mBubbles = 0; mFlushes = 0;
    clearModel();
    setInstr(1'b1, 1, 2, 3, CTRL_ADD);
    @(posedge clk);
    #1;

    // Reset with random ID contents.
    reset = 1'b1;
    setInstr(1'b1, $urandom_range(31), $urandom_range(31), $urandom_range(31), 8'($urandom));
    applyStimulus();
    applyStimulus();
    checkOutput("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
    reset = 1'b0;

    // Pass-through: add x3,x1,x2.
    sendInstr(1, 2, 3, CTRL_ADD, st);
    checkOutput("pass_ctrl", 64'(ex_ctrl), 64'h11);
    checkOutput("pass_rd", 64'(ex_rd), 64'd3);
    checkOutput("pass_valid", {63'd0, ex_valid}, 64'd1);

    // Load-use: ld x5,0(x6) then add x7,x5,x1.
    sendInstr(6, 0, 5, CTRL_LD, st);
    sendInstr(5, 1, 7, CTRL_ADD, st);
    checkOutput("loaduse_stalls", 64'(st), 64'd1);
    checkOutput("loaduse_bcnt", 64'(bubble_cnt), 64'd1);
    checkOutput("loaduse_rd", 64'(ex_rd), 64'd7);

    // Loads into x0, and a load with no dependent consumer.
    sendInstr(6, 0, 0, CTRL_LD, st);
    sendInstr(0, 1, 7, CTRL_ADD, st);
    checkOutput("x0_stalls", 64'(st), 64'd0);
    sendInstr(6, 0, 5, CTRL_LD, st);
    sendInstr(1, 2, 7, CTRL_ADD, st);
    checkOutput("nodep_stalls", 64'(st), 64'd0);
    checkOutput("nodep_bcnt", 64'(bubble_cnt), 64'd1);

    // Back-to-back dependent loads: each costs one bubble.
    sendInstr(6, 0, 5, CTRL_LD, st);
    sendInstr(5, 0, 8, CTRL_LD, st);
    checkOutput("b2b_first", 64'(st), 64'd1);
    sendInstr(8, 1, 9, CTRL_ADD, st);
    checkOutput("b2b_second", 64'(st), 64'd1);

    // Flush together with a hazard: flush wins.
    sendInstr(6, 0, 5, CTRL_LD, st);
    bBefore = mBubbles;
    setInstr(1'b1, 5, 1, 7, CTRL_ADD);
    flush_i = 1'b1;
    applyStimulus();
    flush_i = 1'b0;
    checkOutput("flush_bcnt", 64'(bubble_cnt), 64'(bBefore));
    checkOutput("flush_fcnt", 64'(flush_cnt), 64'd1);
    checkOutput("flush_ctrl", 64'(ex_ctrl), 64'd0);

    // Hold for three cycles.
    sendInstr(1, 2, 10, CTRL_ADD, st);
    hold_i = 1'b1;
    setInstr(1'b1, 3, 4, 11, CTRL_ADD);
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("hold_rd", 64'(ex_rd), 64'd10);
    hold_i = 1'b0;

    // Reset while a load-use stall is pending.
    sendInstr(6, 0, 5, CTRL_LD, st);
    setInstr(1'b1, 5, 1, 7, CTRL_ADD);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midreset_valid", {63'd0, ex_valid}, 64'd0);

    // Drive the bubble counter into saturation.
    for (int k = 0; k < CNT_MAX + 3; k++) begin
      sendInstr(6, 0, 5, CTRL_LD, st);
      sendInstr(5, 1, 7, CTRL_ADD, st);
    end
    checkOutput("bcnt_saturated", 64'(bubble_cnt), 64'(CNT_MAX));

    // Random traffic with a small register pool so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      if (!lastStall) begin
        setInstr($urandom_range(99) < 85, $urandom_range(3), $urandom_range(3),
                 $urandom_range(3),
                 ($urandom_range(99) < 40) ? CTRL_LD : 8'($urandom) & 8'hBF);
      end
      flush_i = ($urandom_range(99) < 10);
      hold_i  = ($urandom_range(99) < 10);
      reset   = ($urandom_range(99) < 2);
      applyStimulus();
    end
    reset = 1'b0; flush_i = 1'b0; hold_i = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
